// File: rtl/rv32i_types.sv
// rv32i_types
// Shared types for the CPU memory responder slice.
//   mem_port_state_t : per-port responder FSM state (IDLE, BUSY, RESP)
//   MEM_LAT_W        : width of the per-port latency counter (LAT up to 15)
package rv32i_types;

  localparam int MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_port_state_t;

endpackage

// File: rtl/mem_resp_port.sv
// mem_resp_port
// One accept/latency/respond FSM for a memory port. It captures the request
// attributes on acceptance, counts out the latency and raises `commit` during
// the cycle whose closing edge moves the FSM into RESP. The top performs the
// array access on that edge. `resp` is high for the single RESP cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rd_req, wr_req    request inputs (a port without writes ties wr_req low)
//   address, wdata,   request attributes, sampled on acceptance
//   wmask
//   commit            array access happens on the closing edge of this cycle
//   resp              completion pulse (state RESP)
//   eff_*             attributes the top uses while commit is high
module mem_resp_port
  import rv32i_types::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        commit,
  output logic        resp,
  output logic [31:0] eff_address,
  output logic [31:0] eff_wdata,
  output logic [3:0]  eff_wmask,
  output logic        eff_rd,
  output logic        eff_wr
);

  localparam logic [MEM_LAT_W-1:0] LAT_M1 = MEM_LAT_W'(LAT - 1);

  mem_port_state_t        state_q, state_d;
  logic [MEM_LAT_W-1:0]   cnt_q, cnt_d;
  logic                   accept;

  logic [31:0] address_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        rd_q;
  logic        wr_q;

  assign accept = (state_q == IDLE) && (rd_req || wr_req);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request attributes: only meaningful once accepted, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      address_q <= address;
      wdata_q   <= wdata;
      wmask_q   <= wmask;
      rd_q      <= rd_req;
      wr_q      <= wr_req;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_M1;
          state_d = (LAT > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == MEM_LAT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. With LAT=1 the commit edge is the acceptance edge itself, so
  // the live request attributes are forwarded while in IDLE.
  always_comb begin
    resp   = (state_q == RESP);
    commit = ((LAT == 1) && accept) ||
             ((state_q == BUSY) && (cnt_q == MEM_LAT_W'(1)));
    if (state_q == IDLE) begin
      eff_address = address;
      eff_wdata   = wdata;
      eff_wmask   = wmask;
      eff_rd      = rd_req;
      eff_wr      = wr_req;
    end else begin
      eff_address = address_q;
      eff_wdata   = wdata_q;
      eff_wmask   = wmask_q;
      eff_rd      = rd_q;
      eff_wr      = wr_q;
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Dual-port memory responder for the RV32I datapath. Port A is the read-only
// instruction port, port B the byte-masked read/write data port. Each port has
// its own latency FSM (mem_resp_port); the word array, read capture and write
// merge live here.
//
// Optional feature: define MEM_RESP_BYPASS_EN to forward a B write into a
// port-A read of the same word committing on the same edge. Without it A
// returns the pre-write word.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   read_a, address_a            instruction read request / byte address
//   resp_a, rdata_a              port A completion pulse / read word
//   read_b, write, wmask,        data request, byte enables, byte address,
//   address_b, wdata             write data
//   resp_b, rdata_b              port B completion pulse / read word
module cpu_mem_responder
  import rv32i_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT_A       = 1,
  parameter int LAT_B       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  logic        commit_a, commit_b;
  logic [31:0] a_address, b_address;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_wmask, b_wmask;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [31:0] rd_word_a;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

  mem_resp_port #(.LAT(LAT_A)) u_port_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_req      (read_a),
    .wr_req      (1'b0),
    .address     (address_a),
    .wdata       (32'd0),
    .wmask       (4'd0),
    .commit      (commit_a),
    .resp        (resp_a),
    .eff_address (a_address),
    .eff_wdata   (a_wdata),
    .eff_wmask   (a_wmask),
    .eff_rd      (a_rd),
    .eff_wr      (a_wr)
  );

  mem_resp_port #(.LAT(LAT_B)) u_port_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_req      (read_b),
    .wr_req      (write),
    .address     (address_b),
    .wdata       (wdata),
    .wmask       (wmask),
    .commit      (commit_b),
    .resp        (resp_b),
    .eff_address (b_address),
    .eff_wdata   (b_wdata),
    .eff_wmask   (b_wmask),
    .eff_rd      (b_rd),
    .eff_wr      (b_wr)
  );

  // Byte offset and bits above the array size are dropped (address wraps).
  assign idx_a = a_address[IDX_W+1:2];
  assign idx_b = b_address[IDX_W+1:2];

`ifdef MEM_RESP_BYPASS_EN
  always_comb begin
    rd_word_a = mem[idx_a];
    if (commit_b && b_wr && (idx_a == idx_b))
      rd_word_a = merge_bytes(mem[idx_a], b_wdata, b_wmask);
  end
`else
  assign rd_word_a = mem[idx_a];
`endif

  // Array write on the B commit edge; a zero mask leaves the word unchanged.
  always_ff @(posedge clk) begin
    if (commit_b && b_wr)
      mem[idx_b] <= merge_bytes(mem[idx_b], b_wdata, b_wmask);
  end

  // Read capture. A combined B read+write captures the pre-write word since
  // the array update above lands on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (commit_a && a_rd) rdata_a <= rd_word_a;
      if (commit_b && b_rd) rdata_b <= mem[idx_b];
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  localparam int LAT_A  = 1;
  localparam int LAT_B  = 2;
  localparam int LAT_A3 = 3;

`ifdef MEM_RESP_BYPASS_EN
  localparam logic [31:0] COLL_EXP = 32'hCAFEF00D;
`else
  localparam logic [31:0] COLL_EXP = 32'h11111111;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Default-latency DUT
  logic        read_a, read_b, write, resp_a, resp_b;
  logic [31:0] address_a, address_b, wdata, rdata_a, rdata_b;
  logic [3:0]  wmask;

  // LAT_A=3 DUT for the back-to-back cadence test
  logic        r3_read_a, r3_read_b, r3_write, r3_resp_a, r3_resp_b;
  logic [31:0] r3_address_a, r3_address_b, r3_wdata, r3_rdata_a, r3_rdata_b;
  logic [3:0]  r3_wmask;

  exp_t q_a[$], q_b[$], q3_a[$], q3_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_responder #(.DEPTH_WORDS(1024), .LAT_A(LAT_A), .LAT_B(LAT_B)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b)
  );

  cpu_mem_responder #(.DEPTH_WORDS(1024), .LAT_A(LAT_A3), .LAT_B(LAT_B)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .read_a(r3_read_a), .address_a(r3_address_a), .resp_a(r3_resp_a), .rdata_a(r3_rdata_a),
    .read_b(r3_read_b), .write(r3_write), .wmask(r3_wmask), .address_b(r3_address_b),
    .wdata(r3_wdata), .resp_b(r3_resp_b), .rdata_b(r3_rdata_b)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_resp(input string nm, input exp_t e, input logic [31:0] act);
    n_checks++;
    if (e.cyc != cyc) begin
      n_fail++;
      $display("FAIL %s timing: pulse in cycle %0d, expected cycle %0d", nm, cyc, e.cyc);
    end
    if (e.chk) check({nm, " data"}, act, e.data);
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected pulse in cycle %0d, expected none", nm, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a response.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (resp_a) begin
        if (q_a.size() == 0) unexpected("resp_a"); else chk_resp("resp_a", q_a.pop_front(), rdata_a);
      end
      if (resp_b) begin
        if (q_b.size() == 0) unexpected("resp_b"); else chk_resp("resp_b", q_b.pop_front(), rdata_b);
      end
      if (r3_resp_a) begin
        if (q3_a.size() == 0) unexpected("r3_resp_a"); else chk_resp("r3_resp_a", q3_a.pop_front(), r3_rdata_a);
      end
      if (r3_resp_b) begin
        if (q3_b.size() == 0) unexpected("r3_resp_b"); else chk_resp("r3_resp_b", q3_b.pop_front(), r3_rdata_b);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_read(input logic [31:0] addr, input logic [31:0] exp_d);
    read_a    = 1'b1;
    address_a = addr;
    q_a.push_back(exp_t'{cyc + LAT_A, exp_d, 1'b1});
    idle(1);
    read_a = 1'b0;
  endtask

  task automatic b_op(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] wm,
                      input logic [31:0] exp_d, input bit chk);
    write     = wr;
    read_b    = rd;
    address_b = addr;
    wdata     = wd;
    wmask     = wm;
    q_b.push_back(exp_t'{cyc + LAT_B, exp_d, chk});
    idle(1);
    write  = 1'b0;
    read_b = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {read_a, read_b, write} = '0;
    address_a = '0; address_b = '0; wdata = '0; wmask = '0;
    {r3_read_a, r3_read_b, r3_write} = '0;
    r3_address_a = '0; r3_address_b = '0; r3_wdata = '0; r3_wmask = '0;

    #3;
    check("reset resp_a", {31'd0, resp_a}, 32'd0);
    check("reset resp_b", {31'd0, resp_b}, 32'd0);
    check("reset rdata_a", rdata_a, 32'd0);
    check("reset rdata_b", rdata_b, 32'd0);
    #9 rst_n = 1'b1;
    idle(1);

    // Full-word write, then instruction read of it
    b_op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0); idle(3);
    a_read(32'h100, 32'hDEADBEEF); idle(2);

    // Partial and empty byte masks
    b_op(1'b1, 1'b0, 32'h100, 32'h000000AA, 4'b0001, 32'd0, 1'b0); idle(3);
    b_op(1'b0, 1'b1, 32'h100, 32'd0, 4'b0000, 32'hDEADBEAA, 1'b1); idle(3);
    b_op(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0); idle(3);
    a_read(32'h100, 32'hDEADBEAA); idle(2);

    // Same-edge A read / B write collision
    b_op(1'b1, 1'b0, 32'h300, 32'h11111111, 4'b1111, 32'd0, 1'b0); idle(3);
    b_op(1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 4'b1111, 32'd0, 1'b0);
    a_read(32'h300, COLL_EXP); idle(3);
    a_read(32'h300, 32'hCAFEF00D); idle(2);

    // Address wrap and ignored byte offset
    b_op(1'b1, 1'b0, 32'h0, 32'h0F0F1234, 4'b1111, 32'd0, 1'b0); idle(3);
    a_read(32'h1000, 32'h0F0F1234); idle(2);
    b_op(1'b0, 1'b1, 32'h1002, 32'd0, 4'b0000, 32'h0F0F1234, 1'b1); idle(3);

    // Combined read+write on B returns the pre-write word
    b_op(1'b1, 1'b0, 32'h200, 32'h01020304, 4'b1111, 32'd0, 1'b0); idle(3);
    b_op(1'b1, 1'b1, 32'h200, 32'hA0B0C0D0, 4'b1111, 32'h01020304, 1'b1); idle(3);
    a_read(32'h200, 32'hA0B0C0D0); idle(2);

    // Reset while a B write is in flight
    b_op(1'b1, 1'b0, 32'h40, 32'h0BADF00D, 4'b1111, 32'd0, 1'b0); idle(3);
    b_op(1'b0, 1'b1, 32'h40, 32'd0, 4'b0000, 32'h0BADF00D, 1'b1); idle(3);
    write = 1'b1; address_b = 32'h40; wdata = 32'h12345678; wmask = 4'b1111;
    idle(1);
    write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset resp_b", {31'd0, resp_b}, 32'd0);
    check("mid-reset rdata_a", rdata_a, 32'd0);
    check("mid-reset rdata_b", rdata_b, 32'd0);
    idle(2);
    check("held-reset resp_b", {31'd0, resp_b}, 32'd0);
    #2 rst_n = 1'b1;
    idle(1);
    b_op(1'b0, 1'b1, 32'h40, 32'd0, 4'b0000, 32'h0BADF00D, 1'b1); idle(3);

    // Held read on the LAT_A=3 instance: pulses every 4 cycles
    r3_write = 1'b1; r3_address_b = 32'h80; r3_wdata = 32'h55AA55AA; r3_wmask = 4'b1111;
    q3_b.push_back(exp_t'{cyc + LAT_B, 32'd0, 1'b0});
    idle(1);
    r3_write = 1'b0;
    idle(3);
    r3_read_a = 1'b1; r3_address_a = 32'h80;
    q3_a.push_back(exp_t'{cyc + 3,  32'h55AA55AA, 1'b1});
    q3_a.push_back(exp_t'{cyc + 7,  32'h55AA55AA, 1'b1});
    q3_a.push_back(exp_t'{cyc + 11, 32'h55AA55AA, 1'b1});
    idle(9);
    r3_read_a = 1'b0;   // third access is in BUSY here and must still complete
    idle(8);

    check("pending q_a", q_a.size(), 0);
    check("pending q_b", q_b.size(), 0);
    check("pending q3_a", q3_a.size(), 0);
    check("pending q3_b", q3_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
